ysyx_22040895_fetch_ctrl: RTL and testbench

Sequencer between the PC/IFU datapath and the instruction memory port. Owns the fetch PC and issues one valid/ready request at a time. Delivers each returned instruction with its PC to decode through a one-entry holding buffer. Applies redirects (branch/jump dnpc) at any point, discarding stale in-flight responses, and raises a sticky fault on memory error.

---
 rtl/ysyx_22040895_fetch_ctrl_if.sv | 23 ++
 rtl/ysyx_22040895_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_ysyx_22040895_fetch_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_fetch_ctrl_if.sv
// Instruction-memory port between the fetch sequencer and memory:
// a valid/ready request channel and a single-cycle response channel.
interface ysyx_22040895_fetch_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [INST_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_22040895_fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one memory request in flight, and
// buffers each returned instruction for decode. Redirects discard stale replies.
module ysyx_22040895_fetch_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int                PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22040895_fetch_ctrl_if.master mem,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic [INST_W-1:0]    inst_o,
  output logic [ADDR_W-1:0]    pc_o,
  input  logic                 redirect_i,
  input  logic [ADDR_W-1:0]    redirect_pc_i,
  output logic                 fault_o,
  output logic [ADDR_W-1:0]    fault_pc_o,
  output logic [63:0]          fetch_cnt_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] buf_q;
  logic [ADDR_W-1:0] bufpc_q, fault_pc_q;
  logic              fault_q;
  logic [63:0]       cnt_q;
  logic              ld_buf, set_fault, clr_fault, cnt_inc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    ld_buf    = 1'b0;
    set_fault = 1'b0;
    clr_fault = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_i) pc_d = redirect_pc_i;
        if (mem.req_ready) begin
          state_d = WAIT;
          // A redirect coinciding with acceptance leaves an orphan reply to drop.
          drop_d  = redirect_i;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (mem.rsp_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (mem.rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (mem.rsp_err) begin
            set_fault = 1'b1;
            state_d   = ERR;
          end else begin
            ld_buf  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready_i) begin
          cnt_inc = 1'b1;
          pc_d    = pc_q + ADDR_W'(PC_STEP);
        end
        // Redirect target overrides the sequential step even when consumed.
        if (redirect_i) pc_d = redirect_pc_i;
        if (inst_ready_i || redirect_i) state_d = REQ;
      end
      ERR: begin
        if (redirect_i) begin
          pc_d      = redirect_pc_i;
          clr_fault = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      buf_q      <= '0;
      bufpc_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (ld_buf) begin
        buf_q   <= mem.rsp_data;
        bufpc_q <= pc_q;
      end
      if (set_fault) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
      end else if (clr_fault) begin
        fault_q <= 1'b0;
      end
      if (cnt_inc) cnt_q <= cnt_q + 64'd1;
    end
  end

  assign mem.req_valid = (state_q == REQ);
  assign mem.req_addr  = pc_q;
  assign inst_valid_o  = (state_q == HOLD);
  assign inst_o        = buf_q;
  assign pc_o          = bufpc_q;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ysyx_22040895_fetch_ctrl.sv
// Directed bench for the fetch sequencer; the bench plays memory and decode
// and checks the Moore outputs 1 ns after each rising edge.
module tb_ysyx_22040895_fetch_ctrl;
  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              inst_valid, inst_ready, redirect, fault;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] pc, redirect_pc, fault_pc;
  logic [63:0]       cnt;
  int                passed = 0;
  int                total  = 0;

  ysyx_22040895_fetch_ctrl_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) mem ();

  ysyx_22040895_fetch_ctrl dut (
    .clk(clk), .rst(rst), .mem(mem),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_o(inst), .pc_o(pc),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .fault_o(fault), .fault_pc_o(fault_pc), .fetch_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem.req_ready = 1'b0; mem.rsp_valid = 1'b0; mem.rsp_data = '0; mem.rsp_err = 1'b0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    total++; if (mem.req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", mem.req_valid); else passed++;
    total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 64'h0) $display("FAIL reset_inst got v=%b i=%h pc=%h want 0/0/0", inst_valid, inst, pc); else passed++;
    total++; if (fault !== 1'b0 || fault_pc !== 64'h0 || cnt !== 64'h0) $display("FAIL reset_fault_cnt got f=%b fpc=%h cnt=%0d want 0/0/0", fault, fault_pc, cnt); else passed++;
  endtask

  task automatic test_first_fetch();
    mem.req_ready = 1'b1;
    rst = 1'b1;
    tick();  // IDLE -> REQ
    total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0000) $display("FAIL first_req got v=%b a=%h want 1/80000000", mem.req_valid, mem.req_addr); else passed++;
    tick();  // accepted -> WAIT
    total++; if (mem.req_valid !== 1'b0) $display("FAIL wait_no_req got %b want 0", mem.req_valid); else passed++;
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'h0000_0413;
    tick();  // -> HOLD
    mem.rsp_valid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || pc !== 64'h8000_0000) $display("FAIL first_inst got v=%b i=%h pc=%h want 1/00000413/80000000", inst_valid, inst, pc); else passed++;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0004 || cnt !== 64'd1) $display("FAIL next_req got v=%b a=%h cnt=%0d want 1/80000004/1", mem.req_valid, mem.req_addr, cnt); else passed++;
  endtask

  task automatic test_backpressure();
    mem.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0004) $display("FAIL req_stall[%0d] got v=%b a=%h want 1/80000004", i, mem.req_valid, mem.req_addr); else passed++;
    end
    mem.req_ready = 1'b1;
    tick();
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'h0010_0093;
    tick();
    mem.rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || pc !== 64'h8000_0004 || cnt !== 64'd1)
        $display("FAIL hold_stall[%0d] got v=%b i=%h pc=%h cnt=%0d want 1/00100093/80000004/1", i, inst_valid, inst, pc, cnt); else passed++;
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (cnt !== 64'd2 || mem.req_addr !== 64'h8000_0008 || inst_valid !== 1'b0) $display("FAIL hold_release got cnt=%0d a=%h v=%b want 2/80000008/0", cnt, mem.req_addr, inst_valid); else passed++;
  endtask

  task automatic test_redirect_wait();
    mem.req_ready = 1'b1;
    tick();  // -> WAIT for 0x80000008
    redirect = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect = 1'b0;
    total++; if (mem.req_valid !== 1'b0 || mem.req_addr !== 64'h8000_0100) $display("FAIL redir_wait got v=%b a=%h want 0/80000100", mem.req_valid, mem.req_addr); else passed++;
    tick();
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'hDEAD_BEEF;
    tick();
    mem.rsp_valid = 1'b0;
    total++; if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF) $display("FAIL stale_drop got v=%b i=%h want 0/not deadbeef", inst_valid, inst); else passed++;
    total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0100) $display("FAIL redir_req got v=%b a=%h want 1/80000100", mem.req_valid, mem.req_addr); else passed++;
  endtask

  task automatic test_redirect_req();
    // redirect while stalled in REQ: new address next cycle
    mem.req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0200) $display("FAIL redir_req_stall got v=%b a=%h want 1/80000200", mem.req_valid, mem.req_addr); else passed++;
    // redirect coinciding with acceptance: old reply must be dropped
    mem.req_ready = 1'b1; redirect_pc = 64'h8000_0008;
    tick();
    redirect = 1'b0;
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'h1111_1111;
    tick();
    mem.rsp_valid = 1'b0;
    total++; if (inst_valid !== 1'b0 || mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0008) $display("FAIL redir_accept got v=%b rv=%b a=%h want 0/1/80000008", inst_valid, mem.req_valid, mem.req_addr); else passed++;
  endtask

  task automatic test_redirect_consume();
    tick();  // -> WAIT for 0x80000008
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'h0000_0013;
    tick();
    mem.rsp_valid = 1'b0;
    total++; if (inst_valid !== 1'b1 || pc !== 64'h8000_0008 || inst !== 32'h0000_0013) $display("FAIL hold_pc got v=%b pc=%h i=%h want 1/80000008/00000013", inst_valid, pc, inst); else passed++;
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_0040;
    tick();
    inst_ready = 1'b0; redirect = 1'b0;
    total++; if (cnt !== 64'd3 || mem.req_addr !== 64'h8000_0040 || mem.req_valid !== 1'b1) $display("FAIL redir_consume got cnt=%0d a=%h v=%b want 3/80000040/1", cnt, mem.req_addr, mem.req_valid); else passed++;
  endtask

  task automatic test_fault();
    mem.req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h8000_0010;
    tick();
    redirect = 1'b0; mem.req_ready = 1'b1;
    tick();  // -> WAIT for 0x80000010
    mem.rsp_valid = 1'b1; mem.rsp_err = 1'b1; mem.rsp_data = 32'h0;
    tick();
    mem.rsp_valid = 1'b0; mem.rsp_err = 1'b0;
    total++; if (fault !== 1'b1 || fault_pc !== 64'h8000_0010) $display("FAIL fault_set got f=%b fpc=%h want 1/80000010", fault, fault_pc); else passed++;
    tick(); tick();
    total++; if (fault !== 1'b1 || mem.req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL fault_hold got f=%b rv=%b iv=%b want 1/0/0", fault, mem.req_valid, inst_valid); else passed++;
    redirect = 1'b1; redirect_pc = 64'h8000_0000; mem.req_ready = 1'b0;
    tick();
    redirect = 1'b0;
    total++; if (fault !== 1'b0 || mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0000) $display("FAIL fault_clear got f=%b rv=%b a=%h want 0/1/80000000", fault, mem.req_valid, mem.req_addr); else passed++;
  endtask

  task automatic test_async_reset();
    mem.req_ready = 1'b1;
    tick();  // -> WAIT
    #2 rst = 1'b0;
    #1;
    total++; if (mem.req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 64'h0) $display("FAIL async_rst_inst got rv=%b iv=%b i=%h pc=%h want 0/0/0/0", mem.req_valid, inst_valid, inst, pc); else passed++;
    total++; if (fault !== 1'b0 || fault_pc !== 64'h0 || cnt !== 64'h0) $display("FAIL async_rst_cnt got f=%b fpc=%h cnt=%0d want 0/0/0", fault, fault_pc, cnt); else passed++;
    tick();
    rst = 1'b1;
    tick();
    total++; if (mem.req_valid !== 1'b1 || mem.req_addr !== 64'h8000_0000) $display("FAIL post_rst_req got v=%b a=%h want 1/80000000", mem.req_valid, mem.req_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_consume();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
